// File: rtl/spm_responder_if.sv
// spm_responder_if
//   Client/responder bundle for the scratchpad memory (SPM) link.
//   The client drives the request fields and the responder returns data.
//
//   Parameters:
//     ADDR_W  address width
//     DATA_W  data width
//
//   Signals:
//     address     client -> responder  read/write address
//     data_in     client -> responder  write data
//     write       client -> responder  1 = write, 0 = read
//     data_out    responder -> client  registered read data
//     ready       responder -> client  1 = clear sweep done, requests serviced
//     inject_err  client -> responder  (SPM_PARITY_EN only) corrupt stored parity
//     parity_err  responder -> client  (SPM_PARITY_EN only) parity mismatch flag
//
//   Optional feature macro: SPM_PARITY_EN
interface spm_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic              write;
   logic [DATA_W-1:0] data_out;
   logic              ready;
`ifdef SPM_PARITY_EN
   logic              inject_err;
   logic              parity_err;
`endif

`ifdef SPM_PARITY_EN
   modport master (
      output address, data_in, write, inject_err,
      input  data_out, ready, parity_err
   );

   modport slave (
      input  address, data_in, write, inject_err,
      output data_out, ready, parity_err
   );
`else
   modport master (
      output address, data_in, write,
      input  data_out, ready
   );

   modport slave (
      input  address, data_in, write,
      output data_out, ready
   );
`endif
endinterface

// File: rtl/spm_responder.sv
// spm_responder
//   Scratchpad memory on the responder side of the SPM link. After reset,
//   every entry is swept to CLEAR_VAL, one entry per cycle. When the sweep
//   finishes, ready rises and one request is serviced per clock. Writes
//   are passed through to data_out. Reads return mem[address] one cycle
//   later.
//
//   Parameters:
//     ADDR_W     address width, depth = 2^ADDR_W
//     DATA_W     data width
//     CLEAR_VAL  value written to every entry by the post-reset sweep
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   spm_responder_if slave modport (address/data_in/write in,
//           data_out/ready out, plus inject_err/parity_err with parity)
//
//   Optional feature macro: SPM_PARITY_EN. This adds one even-parity bit
//   per entry, the inject_err input, and the parity_err output.
//   The bus interface must be instantiated with the same ADDR_W/DATA_W.
module spm_responder #(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input logic        clk,
   input logic        rst,
   spm_responder_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

`ifdef SPM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
   localparam logic [MEM_W-1:0] CLEAR_WORD = {^CLEAR_VAL, CLEAR_VAL};
`else
   localparam int MEM_W = DATA_W;
   localparam logic [MEM_W-1:0] CLEAR_WORD = CLEAR_VAL;
`endif

   typedef enum logic {
      CLEAR = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [PTR_W-1:0]  clr_ptr;
   logic [PTR_W-1:0]  next_clr_ptr;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [MEM_W-1:0]  mem_wdata;
   logic [MEM_W-1:0]  write_word;
   logic [MEM_W-1:0]  rd_word;
   logic [MEM_W-1:0]  mem [DEPTH];

   // Build the stored word for a client write. With parity, the extra bit
   // makes the whole word even. inject_err flips that bit so a later read
   // reports the mismatch.
`ifdef SPM_PARITY_EN
   assign write_word = {(^bus.data_in) ^ bus.inject_err, bus.data_in};
`else
   assign write_word = bus.data_in;
`endif

   assign rd_word   = mem[bus.address];
   assign bus.ready = (state == SERVE);

   // State register and sweep pointer. Reset restarts the sweep at entry 0,
   // so contents from before the reset are always overwritten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= next_state;
         clr_ptr <= next_clr_ptr;
      end
   end

   // Next-state and memory write-port steering. During the sweep, the
   // client request is ignored completely and the port belongs to clr_ptr.
   // The pointer stops on the last entry instead of wrapping, so each entry
   // is swept exactly once.
   always_comb begin
      next_state   = state;
      next_clr_ptr = clr_ptr;
      mem_we       = 1'b0;
      mem_addr     = bus.address;
      mem_wdata    = write_word;
      case (state)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_ptr[ADDR_W-1:0];
            mem_wdata = CLEAR_WORD;
            if (clr_ptr == LAST_PTR) begin
               next_state = SERVE;
            end else begin
               next_clr_ptr = clr_ptr + 1'b1;
            end
         end
         SERVE: begin
            mem_we = bus.write;
         end
         default: begin
            next_state = CLEAR;
         end
      endcase
   end

   // Storage array. It has no reset; the sweep defines its contents.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   // Registered response. A write returns its own data. A read returns the
   // array contents before this edge's update. Because only one request
   // happens per cycle, a read on the next cycle sees the new data.
   // With parity, XOR-reducing the whole stored word is zero when it is intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.data_out   <= '0;
`ifdef SPM_PARITY_EN
         bus.parity_err <= 1'b0;
`endif
      end else if (state == SERVE) begin
         if (bus.write) begin
            bus.data_out   <= bus.data_in;
`ifdef SPM_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
         end else begin
            bus.data_out   <= rd_word[DATA_W-1:0];
`ifdef SPM_PARITY_EN
            bus.parity_err <= ^rd_word;
`endif
         end
      end
   end
endmodule
